// File: rtl/distance_smoother_pkg.sv
// distance_smoother_pkg: shared constants, state encoding and window helpers
package distance_smoother_pkg;

   localparam int DIST_W          = 16;
   localparam int RCNT_W          = 8;
   localparam int CLK_HZ          = 50_000_000;
   localparam int TIMEOUT_DEFAULT = CLK_HZ / 10;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int win_depth(input int log2_win);
      return 1 << log2_win;
   endfunction

   function automatic int sum_width(input int log2_win);
      return DIST_W + log2_win;
   endfunction

endpackage

// File: rtl/distance_smoother_if.sv
// distance_smoother_if: measurement input and smoothed/status output bundle
interface distance_smoother_if
   import distance_smoother_pkg::*;
   ;
   logic              done_in;
   logic [DIST_W-1:0] distance_in;
   logic              out_valid;
   logic [DIST_W-1:0] distance_out;
   logic              reject;
   logic [RCNT_W-1:0] reject_count;
   logic              stale;

   modport master (
      output done_in, distance_in,
      input  out_valid, distance_out, reject, reject_count, stale
   );

   modport slave (
      input  done_in, distance_in,
      output out_valid, distance_out, reject, reject_count, stale
   );
endinterface

// File: rtl/distance_smoother_range_gate.sv
// distance_smoother_range_gate: in-range compare, reject strobe and saturating reject counter
module distance_smoother_range_gate
   import distance_smoother_pkg::*;
#(
   parameter int MIN_MM = 20,
   parameter int MAX_MM = 4000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_event,
   input  logic [DIST_W-1:0] i_distance,
   output logic              o_in_range,
   output logic              o_reject,
   output logic [RCNT_W-1:0] o_reject_count
);

   logic w_rej;

   // classify the current sample and flag an out-of-range event
   always_comb begin
      o_in_range = (i_distance >= DIST_W'(MIN_MM)) && (i_distance <= DIST_W'(MAX_MM));
      w_rej      = i_event && !o_in_range;
   end

   // one-cycle reject strobe and counter that sticks at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_reject       <= 1'b0;
         o_reject_count <= '0;
      end else begin
         o_reject       <= w_rej;
         o_reject_count <= (w_rej && o_reject_count != '1) ? o_reject_count + 1'b1 : o_reject_count;
      end
   end

endmodule

// File: rtl/distance_smoother.sv
// distance_smoother: range-checked moving average of ranging samples with stale detection
module distance_smoother
   import distance_smoother_pkg::*;
#(
   parameter int LOG2_WIN       = 2,
   parameter int MIN_MM         = 20,
   parameter int MAX_MM         = 4000,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   distance_smoother_if.slave bus
);

   localparam int                WIN     = win_depth(LOG2_WIN);
   localparam int                SUM_W   = sum_width(LOG2_WIN);
   localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [LOG2_WIN:0] FILL_LAST = (LOG2_WIN + 1)'(WIN - 1);
   localparam logic [LOG2_WIN:0] FILL_FULL = (LOG2_WIN + 1)'(WIN);

   logic                r_done_d;
   logic                w_event;
   logic                w_in_range;
   logic                w_accept;
   logic [DIST_W-1:0]   r_win [WIN];
   logic [LOG2_WIN-1:0] r_wr_ptr;
   logic [LOG2_WIN:0]   r_fill;
   logic [SUM_W-1:0]    r_sum;
   logic                r_acc_d;
   logic                r_out_valid;
   logic [DIST_W-1:0]   r_dist_out;
   logic [TMO_W-1:0]    r_tmo;
   state_e              r_state;
   state_e              w_state_nxt;
   logic                w_publish;

   // remember previous done_in so a held-high pulse yields a single event
   always_ff @(posedge clk) begin
      r_done_d <= rst_n ? bus.done_in : 1'b0;
   end

   assign w_event  = bus.done_in && !r_done_d;
   assign w_accept = w_event && w_in_range;

   distance_smoother_range_gate #(
      .MIN_MM (MIN_MM),
      .MAX_MM (MAX_MM)
   ) u_gate (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_event        (w_event),
      .i_distance     (bus.distance_in),
      .o_in_range     (w_in_range),
      .o_reject       (bus.reject),
      .o_reject_count (bus.reject_count)
   );

   // circular window with running sum: oldest entry leaves as the new one enters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WIN; i++) r_win[i] <= '0;
         r_sum    <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
      end else if (w_accept) begin
         r_win[r_wr_ptr] <= bus.distance_in;
         r_sum           <= r_sum - SUM_W'(r_win[r_wr_ptr]) + SUM_W'(bus.distance_in);
         r_wr_ptr        <= r_wr_ptr + 1'b1;
         r_fill          <= (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
      end
   end

   // controller state register
   always_ff @(posedge clk) begin
      r_state <= rst_n ? w_state_nxt : FILL;
   end

   // FILL moves to RUN on the accept that completes the window; RUN is left only by reset
   always_comb begin
      w_state_nxt = (r_state == FILL && w_accept && r_fill == FILL_LAST) ? RUN : r_state;
   end

   // publish one edge after an accept, using the sum registered on that accept
   always_comb begin
      w_publish = r_acc_d && (r_state == RUN);
   end

   // output strobe and held smoothed value; reset drops any pending strobe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc_d     <= 1'b0;
         r_out_valid <= 1'b0;
         r_dist_out  <= '0;
      end else begin
         r_acc_d     <= w_accept;
         r_out_valid <= w_publish;
         r_dist_out  <= w_publish ? r_sum[SUM_W-1:LOG2_WIN] : r_dist_out;
      end
   end

   // cycles since the last accept, parked at the timeout value
   always_ff @(posedge clk) begin
      if (!rst_n) r_tmo <= '0;
      else r_tmo <= w_accept ? '0 : (r_tmo == TMO_MAX) ? r_tmo : r_tmo + 1'b1;
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.distance_out = r_dist_out;
   assign bus.stale        = (r_tmo == TMO_MAX);

endmodule

// File: tb/tb_distance_smoother.sv
// tb_distance_smoother: table vectors, corner sequences and randomized run against a queue model
module tb_distance_smoother;

   localparam int LOG2_WIN = 2;
   localparam int WIN      = 1 << LOG2_WIN;
   localparam int MIN_MM   = 20;
   localparam int MAX_MM   = 4000;
   localparam int TMO      = 100;

   typedef struct {
      int d;
      int hold;
      int nv;
      int out;
      int nr;
      int rc;
   } row_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   bit   chk_en;

   distance_smoother_if bus ();

   distance_smoother #(
      .LOG2_WIN       (LOG2_WIN),
      .MIN_MM         (MIN_MM),
      .MAX_MM         (MAX_MM),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural reference: last WIN accepted samples kept in a queue
   int          q[$];
   int          acc_n, idle, rc, pend_avg;
   bit          prev, pend, e_valid, e_reject, e_stale;
   logic [15:0] e_out;

   always @(posedge clk) begin
      bit ev, inr;
      int s;
      if (!rst_n) begin
         q.delete();
         acc_n = 0; idle = 0; rc = 0; prev = 0; pend = 0;
         e_valid = 0; e_out = 0; e_reject = 0;
      end else begin
         ev   = bus.done_in && !prev;
         prev = bus.done_in;
         inr  = bus.distance_in >= MIN_MM && bus.distance_in <= MAX_MM;
         e_valid = pend;
         if (pend) e_out = 16'(pend_avg);
         pend = 0;
         e_reject = ev && !inr;
         if (e_reject && rc < 255) rc++;
         if (ev && inr) begin
            q.push_back(int'(bus.distance_in));
            if (q.size() > WIN) void'(q.pop_front());
            acc_n++;
            idle = 0;
            if (acc_n >= WIN) begin
               s = 0;
               foreach (q[i]) s += q[i];
               pend = 1;
               pend_avg = s / WIN;
            end
         end else if (idle < TMO) idle++;
      end
      e_stale = (idle == TMO);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [26:0] dut_pack();
      return {bus.out_valid, bus.distance_out, bus.reject, bus.reject_count, bus.stale};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (chk_en) check("model", 64'(dut_pack()), 64'({e_valid, e_out, e_reject, 8'(rc), e_stale}));
   endtask

   task automatic run_row(input row_t r, input string tag);
      int nv, nr, vk;
      nv = 0; nr = 0; vk = -1;
      bus.done_in = 1'b1;
      bus.distance_in = 16'(r.d);
      for (int k = 0; k < r.hold + 4; k++) begin
         tick();
         if (bus.out_valid) begin nv++; if (vk < 0) vk = k; end
         if (bus.reject) nr++;
         if (k == r.hold - 1) bus.done_in = 1'b0;
      end
      check({tag, "_nvalid"}, 64'(nv), 64'(r.nv));
      if (r.nv > 0) check({tag, "_latency"}, 64'(vk), 64'd1);
      check({tag, "_out"}, 64'(bus.distance_out), 64'(r.out));
      check({tag, "_nreject"}, 64'(nr), 64'(r.nr));
      check({tag, "_rcount"}, 64'(bus.reject_count), 64'(r.rc));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.done_in = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   row_t tbl[13];
   row_t tbl2[7];

   initial begin
      n_chk = 0; n_err = 0; chk_en = 0;
      rst_n = 1'b0;
      bus.done_in = 1'b0;
      bus.distance_in = '0;
      tbl = '{
         '{100, 1, 0, 0, 0, 0}, '{200, 1, 0, 0, 0, 0}, '{300, 2, 0, 0, 0, 0},
         '{400, 1, 1, 250, 0, 0}, '{500, 1, 1, 350, 0, 0}, '{101, 1, 1, 325, 0, 0},
         '{1000, 10, 1, 500, 0, 0}, '{10, 1, 0, 500, 1, 1}, '{5000, 1, 0, 500, 1, 2},
         '{20, 1, 1, 405, 0, 2}, '{4000, 1, 1, 1280, 0, 2}, '{19, 1, 0, 1280, 1, 3},
         '{4001, 3, 0, 1280, 1, 4}
      };
      tbl2 = '{
         '{700, 1, 0, 0, 0, 0}, '{800, 1, 0, 0, 0, 0}, '{900, 1, 0, 0, 0, 0},
         '{40, 1, 0, 0, 0, 0}, '{60, 2, 0, 0, 0, 0}, '{80, 1, 0, 0, 0, 0},
         '{100, 1, 1, 70, 0, 0}
      };
      tick();
      chk_en = 1;
      tick();
      rst_n = 1'b1;
      check("reset_state", 64'(dut_pack()), 64'd0);

      foreach (tbl[i]) run_row(tbl[i], $sformatf("tbl%0d", i));

      // samples two edges apart: each publishes from its own registered sum
      bus.done_in = 1'b1; bus.distance_in = 16'd600;
      tick();
      bus.done_in = 1'b0;
      tick();
      check("b2b_first", 64'({bus.out_valid, bus.distance_out}), 64'({1'b1, 16'd1405}));
      bus.done_in = 1'b1; bus.distance_in = 16'd700;
      tick();
      bus.done_in = 1'b0;
      tick();
      check("b2b_second", 64'({bus.out_valid, bus.distance_out}), 64'({1'b1, 16'd1330}));

      // reject counter saturation
      for (int i = 0; i < 300; i++) begin
         bus.done_in = 1'b1;
         bus.distance_in = (i % 2) ? 16'd10 : 16'd5000;
         tick();
         bus.done_in = 1'b0;
         tick();
      end
      check("rcount_sat", 64'(bus.reject_count), 64'd255);
      check("stale_after_rejects", 64'(bus.stale), 64'd1);

      // accept clears stale; then idle until the timeout
      bus.done_in = 1'b1; bus.distance_in = 16'd900;
      tick();
      check("stale_clear", 64'(bus.stale), 64'd0);
      bus.done_in = 1'b0;
      tick();
      check("stale_clear_valid", 64'(bus.out_valid), 64'd1);
      for (int k = 2; k <= 150; k++) begin
         tick();
         if (k == 99) check("stale_99", 64'(bus.stale), 64'd0);
         if (k == 100) check("stale_100", 64'(bus.stale), 64'd1);
         if (k == 150) check("stale_150", 64'(bus.stale), 64'd1);
      end

      // accept on the edge that would saturate the timeout
      bus.done_in = 1'b1; bus.distance_in = 16'd1500;
      tick();
      bus.done_in = 1'b0;
      for (int k = 1; k <= 99; k++) tick();
      bus.done_in = 1'b1; bus.distance_in = 16'd1600;
      tick();
      check("sat_accept_stale", 64'(bus.stale), 64'd0);
      bus.done_in = 1'b0;
      tick();
      check("sat_accept_valid", 64'({bus.out_valid, bus.stale}), 64'({1'b1, 1'b0}));

      // reset between accept and publish drops the strobe
      bus.done_in = 1'b1; bus.distance_in = 16'd1234;
      tick();
      rst_n = 1'b0;
      bus.done_in = 1'b0;
      tick();
      rst_n = 1'b1;
      check("reset_drops_strobe", 64'(dut_pack()), 64'd0);

      // three samples, reset, then a window of post-reset samples only
      for (int i = 0; i < 3; i++) run_row(tbl2[i], $sformatf("pre%0d", i));
      do_reset();
      check("reset_mid", 64'(dut_pack()), 64'd0);
      for (int i = 3; i < 7; i++) run_row(tbl2[i], $sformatf("post%0d", i));

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         bus.done_in = ($urandom_range(0, 2) != 0);
         bus.distance_in = ($urandom_range(0, 9) < 8) ? 16'($urandom_range(MIN_MM, MAX_MM))
                         : ($urandom_range(0, 1) ? 16'($urandom_range(0, MIN_MM - 1))
                                                 : 16'($urandom_range(MAX_MM + 1, 65535)));
         rst_n = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst_n = 1'b1;
      bus.done_in = 1'b0;
      for (int c = 0; c < 120; c++) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/distance_smoother.md
Name: distance_smoother

Overview:
- Downstream consumer of the ultrasonic ranging stage.
- Takes each completed distance measurement (done pulse plus a 16-bit mm value) and range-checks it against MIN_MM..MAX_MM.
- Keeps a power-of-two moving-average window of accepted samples and publishes a smoothed distance with a one-cycle valid strobe for the waveform/tone mapping logic.
- Flags rejected samples and a stale condition when no valid sample has arrived within a timeout.

Parameters:
- LOG2_WIN, 2, log2 of averaging window depth (window = 4 samples); legal 1..4
- MIN_MM, 20, smallest accepted distance in mm (inclusive)
- MAX_MM, 4000, largest accepted distance in mm (inclusive)
- TIMEOUT_CYCLES, 5000000, clk cycles without an accepted sample before stale asserts (100 ms at 50 MHz)

Ports:
- clk  input  1  50 MHz system clock; all logic on posedge
- rst_n  input  1  synchronous active-low reset
- done_in  input  1  measurement-complete from ranging stage; may stay high more than one cycle
- distance_in  input  16  measured distance in mm; valid whenever done_in is high
- out_valid  output  1  one-cycle strobe: distance_out updated
- distance_out  output  16  smoothed distance in mm
- reject  output  1  one-cycle strobe: sample outside MIN_MM..MAX_MM was discarded
- reject_count  output  8  saturating count of rejected samples
- stale  output  1  high while no sample accepted for TIMEOUT_CYCLES or more

Behaviour:
- Reset (rst_n low at a posedge) clears all of the following: out_valid, reject, stale; distance_out, reject_count, running sum, write pointer and fill counter go to 0; all window entries go to 0; edge-detect register goes to 0; timeout counter goes to 0.
- Reset mid-operation discards any partial window and any pending output strobe.
- Event detection: a sample event occurs at posedge T when done_in=1 and the registered previous done_in=0. A held-high done_in produces exactly one event.
- Accept (edge T), when the event is in range (MIN_MM <= distance_in <= MAX_MM):
  - window[wr_ptr] <= distance_in
  - sum <= sum - window[wr_ptr] + distance_in
  - wr_ptr increments modulo 2^LOG2_WIN
  - fill counter increments, saturating at 2^LOG2_WIN
  - timeout counter <= 0; stale <= 0
- Reject (edge T), when the event is out of range:
  - no window, sum or pointer change
  - reject=1 for the cycle after T
  - reject_count increments, saturating at 255
  - timeout counter is not cleared
- Output (edge T+1): if the sample at T was accepted and the fill counter equals 2^LOG2_WIN, then distance_out <= sum >> LOG2_WIN (truncating) and out_valid=1 for exactly one cycle. Latency is 2 posedges from done_in rising.
- While filling (fewer than 2^LOG2_WIN accepted since reset): no out_valid; distance_out holds 0.
- Widths: sum is 16+LOG2_WIN bits and never overflows. Window entries are 16 bits. distance_out fits 16 bits.
- Timeout counter: increments each cycle when no accept occurs, saturating at TIMEOUT_CYCLES. stale=1 when the counter equals TIMEOUT_CYCLES. stale clears on the edge of the next accepted sample. Window contents are retained across stale.
- Simultaneous events:
  - An accept on the same edge as timeout saturation: accept wins and stale stays 0.
  - A new done_in rise at T+1 (back-to-back) is legal. Output logic uses the sum registered at T, and the new sample updates the sum at T+1 independently.
- Controller states:
  - FILL: fill counter below 2^LOG2_WIN. Moves to RUN on the accept that fills the window.
  - RUN: window full. Leaves only on reset.
  - The stale flag is orthogonal to FILL/RUN.

Decomposition:
- Shared package holds: the window-depth derivation (WIN = 1 << LOG2_WIN), the sum width constant, the state encoding (FILL, RUN), and the 50 MHz clock-rate constant used to derive TIMEOUT_CYCLES.
- One natural sub-module, range_gate: a combinational in-range compare plus the registered reject strobe and saturating reject counter.
- The window RAM, sum and timeout logic stay in the top module.

Test Plan:
- Reset, then 4 done_in pulses with distances 100, 200, 300, 400 -> out_valid once, 2 cycles after the 4th rise, distance_out=250; no out_valid after pulses 1–3.
- Continue with a 5th sample of 500 -> out_valid with distance_out=350 (window 200..500). A 6th sample of 101 -> (300+400+500+101)>>2 = 325.
- Full window, then done_in held high 10 cycles with 1000 -> exactly one event and one out_valid; no duplicates.
- Samples 10 and 5000 -> two reject strobes, reject_count=2, window and distance_out unchanged, no out_valid. Drive 300 rejects -> reject_count saturates at 255.
- No samples for TIMEOUT_CYCLES (set parameter to 100 in bench) -> stale rises at cycle 100 and stays high; next in-range sample -> stale low on the accept edge, and out_valid follows if the window is full.
- Pull rst_n low for one cycle after 3 accepted samples -> all outputs 0; the next 3 samples produce no out_valid, and the 4th produces the average of only the post-reset samples.
